// File: rtl/bp_cfg_param_deserializer.sv
// bp_cfg_param_deserializer
//   Run-time receiver for processor configuration records. Accepts a framed
//   word stream (header, one word per bp_proc_param_s field, XOR checksum),
//   validates the frame and commits the fields to output registers.
// Ports:
//   clk_i      clock
//   reset_i    synchronous active-high reset (also clears committed outputs)
//   clear_i    abort/re-arm; drops cfg_v_o/cfg_err_o, keeps committed record
//   data_i     stream word
//   v_i        data_i valid; a word transfers when v_i & ready_o
//   ready_o    block accepts data_i this cycle
//   cfg_id_o   committed config id
//   fields_o   committed fields, field k at [word_width_p*k +: word_width_p]
//   cfg_v_o    committed record valid
//   cfg_err_o  0 none, 1 bad magic, 2 bad checksum, 3 id==0 or num_core==0
module bp_cfg_param_deserializer #(
    parameter int unsigned num_fields_p = 19,
    parameter logic [7:0]  magic_p      = 8'hBC,
    parameter int unsigned max_cfgs_p   = 128,
    parameter int unsigned word_width_p = 16
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 clear_i,
    input  logic [word_width_p-1:0]              data_i,
    input  logic                                 v_i,
    output logic                                 ready_o,
    output logic [$clog2(max_cfgs_p)-1:0]        cfg_id_o,
    output logic [num_fields_p*word_width_p-1:0] fields_o,
    output logic                                 cfg_v_o,
    output logic [1:0]                           cfg_err_o
);

    localparam int unsigned lg_cfgs_lp = $clog2(max_cfgs_p);
    localparam logic [4:0]  last_idx_lp = 5'(num_fields_p - 1);

    typedef enum logic [2:0] {
        e_header,
        e_fields,
        e_csum,
        e_done,
        e_error
    } state_e;

    state_e state_r, state_n;

    logic [word_width_p-1:0] staging_r [num_fields_p];
    logic [lg_cfgs_lp-1:0]   id_r;
    logic [4:0]              cnt_r;
    logic [word_width_p-1:0] acc_r;

    logic xfer;
    logic hdr_ok, hdr_bad, field_we, csum_err, id_err, commit;

    // Header bit 7 is reserved and deliberately ignored.
    logic unused_hdr_bit7;
    assign unused_hdr_bit7 = data_i[7];

    // ready_o already masks clear_i/reset_i, so every action below is gated by them.
    assign ready_o = ((state_r == e_header) || (state_r == e_fields) || (state_r == e_csum))
                     & ~clear_i & ~reset_i;
    assign xfer    = v_i & ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= e_header;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n  = state_r;
        hdr_ok   = 1'b0;
        hdr_bad  = 1'b0;
        field_we = 1'b0;
        csum_err = 1'b0;
        id_err   = 1'b0;
        commit   = 1'b0;
        unique case (state_r)
            e_header: begin
                if (xfer) begin
                    if (data_i[word_width_p-1 -: 8] == magic_p) begin
                        hdr_ok  = 1'b1;
                        state_n = e_fields;
                    end else begin
                        hdr_bad = 1'b1;
                        state_n = e_error;
                    end
                end
            end
            e_fields: begin
                if (xfer) begin
                    field_we = 1'b1;
                    if (cnt_r == last_idx_lp) state_n = e_csum;
                end
            end
            e_csum: begin
                // Checksum mismatch takes priority over the id/num_core check.
                if (xfer) begin
                    if (data_i != acc_r) begin
                        csum_err = 1'b1;
                        state_n  = e_error;
                    end else if ((id_r == '0) || (staging_r[0] == '0)) begin
                        id_err  = 1'b1;
                        state_n = e_error;
                    end else begin
                        commit  = 1'b1;
                        state_n = e_done;
                    end
                end
            end
            e_done, e_error: begin
                state_n = state_r;
            end
            default: state_n = e_header;
        endcase
        if (clear_i) state_n = e_header;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cfg_v_o   <= 1'b0;
            cfg_err_o <= '0;
            cfg_id_o  <= '0;
            fields_o  <= '0;
            id_r      <= '0;
            cnt_r     <= '0;
            acc_r     <= '0;
            for (int unsigned k = 0; k < num_fields_p; k++) staging_r[k] <= '0;
        end else if (clear_i) begin
            cfg_v_o   <= 1'b0;
            cfg_err_o <= '0;
            cnt_r     <= '0;
            acc_r     <= '0;
        end else begin
            if (hdr_ok) begin
                id_r  <= data_i[lg_cfgs_lp-1:0];
                cnt_r <= '0;
                acc_r <= '0;
            end
            if (hdr_bad) cfg_err_o <= 2'd1;
            if (field_we) begin
                staging_r[cnt_r] <= data_i;
                acc_r            <= acc_r ^ data_i;
                cnt_r            <= cnt_r + 5'd1;
            end
            if (csum_err) cfg_err_o <= 2'd2;
            if (id_err)   cfg_err_o <= 2'd3;
            if (commit) begin
                cfg_v_o  <= 1'b1;
                cfg_id_o <= id_r;
                for (int unsigned k = 0; k < num_fields_p; k++)
                    fields_o[k*word_width_p +: word_width_p] <= staging_r[k];
            end
        end
    end

endmodule

// File: tb/tb_bp_cfg_param_deserializer.sv
module tb_bp_cfg_param_deserializer;

    localparam int NF = 19;
    localparam int FW = NF * 16;

    logic          clk = 1'b0;
    logic          reset_i, clear_i, v_i;
    logic [15:0]   data_i;
    logic          ready_o, cfg_v_o;
    logic [6:0]    cfg_id_o;
    logic [FW-1:0] fields_o;
    logic [1:0]    cfg_err_o;

    bp_cfg_param_deserializer #(
        .num_fields_p(19),
        .magic_p(8'hBC),
        .max_cfgs_p(128),
        .word_width_p(16)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i), .data_i(data_i), .v_i(v_i),
        .ready_o(ready_o), .cfg_id_o(cfg_id_o), .fields_o(fields_o),
        .cfg_v_o(cfg_v_o), .cfg_err_o(cfg_err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [FW-1:0] exp_fields = '0;
    logic [6:0]    exp_id = '0;

    typedef struct {
        logic [15:0] hdr;
        logic [15:0] base;      // field i = base + i
        logic [15:0] csum_xor;  // XORed into the correct checksum (0 = good)
        bit          hdr_only;
        bit          exp_v;
        logic [1:0]  exp_err;
        logic [6:0]  exp_id;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] build_fields(input logic [15:0] base);
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < NF; i++) f[i*16 +: 16] = base + 16'(i);
        return f;
    endfunction

    function automatic logic [15:0] xor_of(input logic [FW-1:0] f);
        logic [15:0] a;
        a = '0;
        for (int i = 0; i < NF; i++) a = a ^ f[i*16 +: 16];
        return a;
    endfunction

    // Drive one word for one cycle; ready must already be asserted.
    task automatic put_word(input logic [15:0] w, input string name);
        data_i = w;
        v_i    = 1'b1;
        #1;
        chk({name, "_ready"}, FW'(ready_o), FW'(1'b1));
        @(posedge clk);
        #1;
        v_i = 1'b0;
    endtask

    task automatic idle(input int n);
        v_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [15:0] hdr, input logic [15:0] base,
                              input logic [15:0] cx, input bit gaps);
        logic [FW-1:0] f;
        f = build_fields(base);
        put_word(hdr, "hdr");
        for (int i = 0; i < NF; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            put_word(f[i*16 +: 16], "fld");
        end
        if (gaps) idle($urandom_range(0, 2));
        put_word(xor_of(f) ^ cx, "csum");
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        #1;
        chk("clear_ready_low", FW'(ready_o), FW'(1'b0));
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        #1;
        chk("clear_err", FW'(cfg_err_o), FW'(2'd0));
        chk("clear_v", FW'(cfg_v_o), FW'(1'b0));
        chk("clear_ready", FW'(ready_o), FW'(1'b1));
        chk("clear_keeps_fields", fields_o, exp_fields);
        chk("clear_keeps_id", FW'(cfg_id_o), FW'(exp_id));
    endtask

    task automatic check_outcome(input string tag, input bit ev, input logic [1:0] ee,
                                 input logic [6:0] eid);
        chk({tag, "_v"}, FW'(cfg_v_o), FW'(ev));
        chk({tag, "_err"}, FW'(cfg_err_o), FW'(ee));
        chk({tag, "_id"}, FW'(cfg_id_o), FW'(eid));
        chk({tag, "_fields"}, fields_o, exp_fields);
        chk({tag, "_ready_held"}, FW'(ready_o), FW'(1'b0));
    endtask

    initial begin
        //                hdr       base      csum_xor  hdr_only v  err  id
        vecs[0] = '{16'hBC02, 16'h0001, 16'h0000, 1'b0, 1'b1, 2'd0, 7'd2};
        vecs[1] = '{16'hAB02, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'd1, 7'd2};
        vecs[2] = '{16'hBC02, 16'h0001, 16'h0015, 1'b0, 1'b0, 2'd2, 7'd2};
        vecs[3] = '{16'hBC00, 16'h0001, 16'h0000, 1'b0, 1'b0, 2'd3, 7'd2};
        vecs[4] = '{16'hBC03, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'd3, 7'd2};
        vecs[5] = '{16'hBC00, 16'h0001, 16'h0001, 1'b0, 1'b0, 2'd2, 7'd2};
        vecs[6] = '{16'hBC85, 16'h0100, 16'h0000, 1'b0, 1'b1, 2'd0, 7'd5};
        vecs[7] = '{16'hBD05, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'd1, 7'd5};
        vecs[8] = '{16'hBC7F, 16'hFFF0, 16'h0000, 1'b0, 1'b1, 2'd0, 7'h7F};

        reset_i = 1'b1;
        clear_i = 1'b0;
        v_i     = 1'b0;
        data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        #1;
        chk("rst_v", FW'(cfg_v_o), FW'(1'b0));
        chk("rst_err", FW'(cfg_err_o), FW'(2'd0));
        chk("rst_id", FW'(cfg_id_o), FW'(7'd0));
        chk("rst_fields", fields_o, '0);
        chk("rst_ready", FW'(ready_o), FW'(1'b1));

        // Table-driven frames, each preceded by a clear.
        for (int k = 0; k < 9; k++) begin
            do_clear();
            if (vecs[k].hdr_only) put_word(vecs[k].hdr, "hdr");
            else send_frame(vecs[k].hdr, vecs[k].base, vecs[k].csum_xor, 1'b0);
            if (vecs[k].exp_v) begin
                exp_fields = build_fields(vecs[k].base);
                exp_id     = vecs[k].exp_id;
            end
            check_outcome($sformatf("vec%0d", k), vecs[k].exp_v, vecs[k].exp_err, vecs[k].exp_id);
            idle(2);
            check_outcome($sformatf("vec%0d_hold", k), vecs[k].exp_v, vecs[k].exp_err,
                          vecs[k].exp_id);
        end

        // Test 1 frame with random valid gaps.
        do_clear();
        send_frame(16'hBC02, 16'h0001, 16'h0000, 1'b1);
        exp_fields = build_fields(16'h0001);
        exp_id     = 7'd2;
        check_outcome("gaps", 1'b1, 2'd0, 7'd2);

        // Abort at field 10 (clear with a word offered), then a fresh frame commits.
        do_clear();
        begin
            logic [FW-1:0] f;
            f = build_fields(16'h0020);
            put_word(16'hBC07, "hdr");
            for (int i = 0; i < 10; i++) put_word(f[i*16 +: 16], "fld");
        end
        data_i = 16'h1234;
        v_i    = 1'b1;
        do_clear();
        v_i = 1'b0;
        send_frame(16'hBC07, 16'h0020, 16'h0000, 1'b0);
        exp_fields = build_fields(16'h0020);
        exp_id     = 7'd7;
        check_outcome("abort_refill", 1'b1, 2'd0, 7'd7);

        // Reset mid-frame after a commit wipes committed outputs.
        do_clear();
        put_word(16'hBC09, "hdr");
        for (int i = 0; i < 5; i++) put_word(16'h0040 + 16'(i), "fld");
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        #1;
        exp_fields = '0;
        exp_id     = '0;
        chk("midrst_v", FW'(cfg_v_o), FW'(1'b0));
        chk("midrst_fields", fields_o, '0);
        chk("midrst_id", FW'(cfg_id_o), FW'(7'd0));
        chk("midrst_ready", FW'(ready_o), FW'(1'b1));

        // clear_i with a bad-magic header offered: the word must be dropped.
        data_i = 16'hAB00;
        v_i    = 1'b1;
        do_clear();
        v_i = 1'b0;
        idle(1);
        chk("clrdrop_err", FW'(cfg_err_o), FW'(2'd0));
        chk("clrdrop_ready", FW'(ready_o), FW'(1'b1));
        send_frame(16'hBC11, 16'h0003, 16'h0000, 1'b0);
        exp_fields = build_fields(16'h0003);
        exp_id     = 7'h11;
        check_outcome("clrdrop_frame", 1'b1, 2'd0, 7'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
